// File: rtl/credit_fifo_sink.sv
// Credit-managed sink FIFO behind a non-stallable delay line.
// Push to out_valid takes 1 cycle. Pop uses valid/ready. The push side cannot be stalled, so credit is withheld upstream instead.
module credit_fifo_sink #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 8,
    parameter int MAX_IN_FLIGHT = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       up_issue,
    output logic                       up_ready,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       error
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int IFM = (MAX_IN_FLIGHT > DEPTH) ? MAX_IN_FLIGHT : DEPTH;
    localparam int IW  = $clog2(IFM + 1);
    localparam int RW  = ((CW > IW) ? CW : IW) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [IW-1:0]    r_in_flight;
    logic             r_error;

    logic          w_pop;
    logic          w_full;
    logic          w_push_ok;
    logic          w_overflow;
    logic          w_orphan;
    logic          w_issue_ok;
    logic          w_issue_bad;
    logic [RW-1:0] w_reserved;

    assign w_full      = (r_count == CW'(DEPTH));
    assign w_pop       = out_valid & out_ready;
    // A full FIFO still accepts an arrival when the head leaves in the same cycle.
    assign w_push_ok   = in_valid & (~w_full | w_pop);
    assign w_overflow  = in_valid & w_full & ~w_pop;
    assign w_orphan    = in_valid & (r_in_flight == '0);
    assign w_reserved  = RW'(r_count) + RW'(r_in_flight);
    assign w_issue_ok  = up_issue & up_ready;
    assign w_issue_bad = up_issue & ~up_ready;

    assign up_ready  = (w_reserved < RW'(DEPTH));
    assign out_valid = (r_count != '0);
    assign out_data  = r_mem[r_rd_ptr];
    assign occupancy = r_count;
    assign error     = r_error;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // An arrival with nothing outstanding is not charged against in_flight, so it never underflows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_flight <= '0;
        end else if (w_issue_ok && !in_valid) begin
            r_in_flight <= r_in_flight + IW'(1);
        end else if (!w_issue_ok && in_valid && (r_in_flight != '0)) begin
            r_in_flight <= r_in_flight - IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_error <= 1'b0;
        end else if (w_issue_bad || w_overflow || w_orphan) begin
            r_error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_credit_fifo_sink.sv
module tb_credit_fifo_sink;
    localparam int D = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       up_issue = 1'b0;
    logic       up_ready;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [3:0] occupancy;
    logic       error;

    credit_fifo_sink #(.WIDTH(8), .DEPTH(D), .MAX_IN_FLIGHT(8)) dut (
        .clk(clk), .rst_n(rst_n), .up_issue(up_issue), .up_ready(up_ready),
        .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .occupancy(occupancy),
        .error(error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference: FIFO contents as a queue, outstanding issues as an integer.
    logic [7:0] mq[$];
    int         minf = 0;
    bit         merr = 1'b0;

    // Delay line stand-in between the upstream issuer and the sink.
    bit         dl_v[8];
    logic [7:0] dl_d[8];
    int         lat = 8;
    logic [7:0] issue_data = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() != 0));
        check({tag, ".occupancy"}, 32'(occupancy), 32'(mq.size()));
        check({tag, ".up_ready"}, 32'(up_ready), 32'((mq.size() + minf) < D));
        check({tag, ".error"}, 32'(error), 32'(merr));
        if (mq.size() != 0) check({tag, ".out_data"}, 32'(out_data), 32'(mq[0]));
    endtask

    task automatic model_update();
        bit rdy, pop, full, iss;
        rdy  = (mq.size() + minf) < D;
        pop  = (mq.size() != 0) && out_ready;
        full = (mq.size() == D);
        iss  = up_issue && rdy;
        if (up_issue && !rdy) merr = 1'b1;
        if (in_valid && minf == 0) merr = 1'b1;
        if (in_valid && full && !pop) merr = 1'b1;
        if (iss && !in_valid) minf++;
        else if (!iss && in_valid && minf > 0) minf--;
        if (pop) void'(mq.pop_front());
        if (in_valid && (!full || pop)) mq.push_back(in_data);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_update();
        for (int i = 7; i > 0; i--) begin
            dl_v[i] = dl_v[i-1];
            dl_d[i] = dl_d[i-1];
        end
        dl_v[0] = up_issue;
        dl_d[0] = issue_data;
        @(negedge clk);
        in_valid = dl_v[lat-1];
        in_data  = dl_d[lat-1];
        check_all(tag);
    endtask

    task automatic clear_model();
        mq.delete();
        minf = 0;
        merr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            dl_v[i] = 1'b0;
            dl_d[i] = 8'h00;
        end
        up_issue = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_all("reset");
    endtask

    // Legally issue n items starting at payload base and wait until all are stored.
    task automatic fill(input int n, input logic [7:0] base);
        int sent = 0;
        for (int cyc = 0; cyc < 200 && mq.size() < n; cyc++) begin
            up_issue   = (sent < n) && up_ready;
            issue_data = base + 8'(sent);
            if (up_issue) sent++;
            tick("fill");
        end
        up_issue = 1'b0;
        check("fill_occupancy", 32'(occupancy), 32'(n));
    endtask

    initial begin
        logic [7:0] exp_seq[8];
        int sent, got, cyc;

        // Reset, then idle.
        do_reset();
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_up_ready", 32'(up_ready), 32'd1);
        check("idle_error", 32'(error), 32'd0);
        repeat (3) tick("idle");

        // Async reset with 5 stored entries.
        lat = 2;
        fill(5, 8'h40);
        rst_n = 1'b0;
        #1;
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_occupancy", 32'(occupancy), 32'd0);
        check("async_up_ready", 32'(up_ready), 32'd1);
        clear_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_all("async_after");

        // Eight back-to-back issues through an 8-deep delay line with no consumer.
        lat = 8;
        for (int k = 0; k < 8; k++) begin
            check("burst_ready_before", 32'(up_ready), 32'd1);
            up_issue = 1'b1;
            issue_data = 8'h80 + 8'(k);
            tick("burst_issue");
        end
        up_issue = 1'b0;
        check("burst_ready_after8", 32'(up_ready), 32'd0);
        repeat (8) tick("burst_arrive");
        check("burst_occupancy", 32'(occupancy), 32'd8);
        check("burst_error_clean", 32'(error), 32'd0);
        up_issue = 1'b1;
        tick("burst_violate");
        up_issue = 1'b0;
        check("burst_error_set", 32'(error), 32'd1);
        do_reset();

        // Ordered stream of 24 items with random issue and consume.
        lat = $urandom_range(1, 8);
        sent = 0;
        got = 0;
        for (cyc = 0; cyc < 3000 && got < 24; cyc++) begin
            up_issue   = (sent < 24) && up_ready && ($urandom_range(0, 1) == 1);
            issue_data = 8'(sent);
            if (up_issue) sent++;
            out_ready = ($urandom_range(0, 2) != 0);
            if (out_valid && out_ready) begin
                check("order_data", 32'(out_data), 32'(got));
                got++;
            end
            tick("order");
        end
        up_issue = 1'b0;
        out_ready = 1'b0;
        check("order_count", 32'(got), 32'd24);
        check("order_error", 32'(error), 32'd0);
        do_reset();

        // Full FIFO with simultaneous pop and arrival.
        lat = 1;
        fill(8, 8'h10);
        in_valid = 1'b1;
        in_data = 8'hA5;
        out_ready = 1'b1;
        check("fpp_head", 32'(out_data), 32'h10);
        tick("fpp");
        check("fpp_occupancy", 32'(occupancy), 32'd8);
        for (int i = 0; i < 7; i++) exp_seq[i] = 8'h11 + 8'(i);
        exp_seq[7] = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            check("fpp_drain", 32'(out_data), 32'(exp_seq[i]));
            tick("fpp_drain");
        end
        out_ready = 1'b0;
        do_reset();

        // Overflow: arrival into a full FIFO with no pop.
        fill(8, 8'h20);
        check("ovf_error_before", 32'(error), 32'd0);
        in_valid = 1'b1;
        in_data = 8'hEE;
        tick("ovf");
        check("ovf_occupancy", 32'(occupancy), 32'd8);
        check("ovf_error", 32'(error), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("ovf_data", 32'(out_data), 32'h20 + 32'(i));
            tick("ovf_drain");
        end
        out_ready = 1'b0;
        do_reset();

        // Single-item latency.
        lat = 1;
        up_issue = 1'b1;
        issue_data = 8'h3C;
        tick("lat_issue");
        up_issue = 1'b0;
        check("lat_no_bypass", 32'(out_valid), 32'd0);
        tick("lat_push");
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_data", 32'(out_data), 32'h3C);
        out_ready = 1'b1;
        tick("lat_pop");
        check("lat_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
